// File: rtl/tc0360pri_mixer.sv
// Per-pixel priority mixer: resolves sprite and two tilemap layers against
// CPU-programmed 4-bit priorities and emits a palette index two pixel ticks later.
module tc0360pri_mixer #(
  parameter logic [13:0] BG_DEFAULT = 14'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pixel,
  input  logic        CS,
  input  logic [3:0]  MA,
  input  logic        RWn,
  input  logic        DSn,
  input  logic [7:0]  MDin,
  output logic [7:0]  MDout,
  output logic        DTACKn,
  input  logic        HBLANKn,
  input  logic        VBLANKn,
  input  logic [15:0] OBJ,
  input  logic [15:0] SCA,
  input  logic [15:0] SCB,
  output logic [13:0] IM,
  output logic        OHBLANKn,
  output logic        OVBLANKn
);

  logic [7:0]  regs [16];
  logic        ack;
  logic        access;

  logic [15:0] pix [3];
  logic [3:0]  eff_pri [3];
  logic [3:0]  pri_addr;

  logic [13:0] s1_idx [3];
  logic [3:0]  s1_pri [3];
  logic        s1_force;
  logic [13:0] s1_bg;
  logic        s1_hb;
  logic        s1_vb;

  logic [13:0] win_idx;
  logic [3:0]  best_pri;

  // One access per strobe: ack blocks repeats until CS is released.
  assign access = CS & ~DSn & ~ack;
  assign DTACKn = ~(CS & ack);

  assign pix[0] = OBJ;
  assign pix[1] = SCA;
  assign pix[2] = SCB;

  // NOTE: the register file is a small flop array (not RAM), so it takes the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      regs[1] <= BG_DEFAULT[7:0];
      regs[2] <= {2'b00, BG_DEFAULT[13:8]};
      ack     <= 1'b0;
      MDout   <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ack <= CS & (ack | ~DSn);
      if (access) begin
        if (!RWn) regs[MA] <= MDin;
        else      MDout    <= regs[MA];
      end
    end
  end

  // Priority nibble lookup for each layer's group; transparent pixels get priority 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pri_addr = 4'h0;
    for (int l = 0; l < 3; l++) begin
      pri_addr   = 4'(4 + 2 * l) + {3'b000, pix[l][15]};
      eff_pri[l] = pix[l][14] ? regs[pri_addr][7:4] : regs[pri_addr][3:0];
      if (pix[l][3:0] == 4'h0) eff_pri[l] = 4'h0;
    end
  end

  // Strict greater-than keeps the lowest layer number on ties.
  always_comb begin
    win_idx  = s1_bg;
    best_pri = 4'h0;
    for (int l = 0; l < 3; l++) begin
      if (s1_pri[l] > best_pri) begin
        best_pri = s1_pri[l];
        win_idx  = s1_idx[l];
      end
    end
    if (s1_force) win_idx = s1_bg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 3; l++) begin
        s1_idx[l] <= 14'h0000;
        s1_pri[l] <= 4'h0;
      end
      s1_force <= 1'b0;
      s1_bg    <= 14'h0000;
      s1_hb    <= 1'b0;
      s1_vb    <= 1'b0;
      IM       <= 14'h0000;
      OHBLANKn <= 1'b0;
      OVBLANKn <= 1'b0;
    end else if (ce_pixel) begin
      for (int l = 0; l < 3; l++) begin
        s1_idx[l] <= pix[l][13:0];
        s1_pri[l] <= eff_pri[l];
      end
      s1_force <= regs[0][0];
      s1_bg    <= {regs[2][5:0], regs[1]};
      s1_hb    <= HBLANKn;
      s1_vb    <= VBLANKn;
      IM       <= win_idx;
      OHBLANKn <= s1_hb;
      OVBLANKn <= s1_vb;
    end
  end

endmodule

// File: tb/tb_tc0360pri_mixer.sv
// Self-checking bench for tc0360pri_mixer: directed scenarios plus randomized
// pixels/register writes against a rule-level reference model.
module tb_tc0360pri_mixer;

  localparam logic [13:0] BG = 14'h2A5C;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pixel;
  logic        CS;
  logic [3:0]  MA;
  logic        RWn;
  logic        DSn;
  logic [7:0]  MDin;
  logic [7:0]  MDout;
  logic        DTACKn;
  logic        HBLANKn;
  logic        VBLANKn;
  logic [15:0] OBJ;
  logic [15:0] SCA;
  logic [15:0] SCB;
  logic [13:0] IM;
  logic        OHBLANKn;
  logic        OVBLANKn;

  int errors = 0;
  int checks = 0;

  tc0360pri_mixer #(.BG_DEFAULT(BG)) dut (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel),
    .CS(CS), .MA(MA), .RWn(RWn), .DSn(DSn), .MDin(MDin), .MDout(MDout), .DTACKn(DTACKn),
    .HBLANKn(HBLANKn), .VBLANKn(VBLANKn),
    .OBJ(OBJ), .SCA(SCA), .SCB(SCB),
    .IM(IM), .OHBLANKn(OHBLANKn), .OVBLANKn(OVBLANKn)
  );

  always #5 clk = ~clk;

  // Reference model state: register image and the two-tick output pipeline.
  logic [7:0]  mreg [16];
  logic [13:0] exp_s1_im, exp_im;
  logic        exp_s1_hb, exp_s1_vb, exp_hb, exp_vb;

  function automatic logic [13:0] model_im(input logic [15:0] o, input logic [15:0] s,
                                           input logic [15:0] b);
    logic [15:0] px [3];
    int          pri [3];
    int          top;
    logic [7:0]  r;
    logic [13:0] bg;
    px[0] = o; px[1] = s; px[2] = b;
    bg  = {mreg[2][5:0], mreg[1]};
    top = 0;
    if (mreg[0][0]) return bg;
    for (int l = 0; l < 3; l++) begin
      r = mreg[4 + 2 * l + int'(px[l][15])];
      if (px[l][3:0] == 4'h0) pri[l] = 0;
      else pri[l] = px[l][14] ? int'(r >> 4) : int'(r & 8'h0F);
      if (pri[l] > top) top = pri[l];
    end
    if (top == 0) return bg;
    for (int l = 0; l < 3; l++)
      if (pri[l] == top) return px[l][13:0];
    return bg;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mreg[1] = BG[7:0];
    mreg[2] = {2'b00, BG[13:8]};
    exp_s1_im = '0; exp_s1_hb = 1'b0; exp_s1_vb = 1'b0;
    exp_im    = '0; exp_hb    = 1'b0; exp_vb    = 1'b0;
  endtask

  // One ce_pixel tick; returns at the following negedge with outputs settled.
  task automatic tick(input logic [15:0] o, input logic [15:0] s, input logic [15:0] b,
                      input logic hb, input logic vb);
    @(negedge clk);
    OBJ = o; SCA = s; SCB = b; HBLANKn = hb; VBLANKn = vb; ce_pixel = 1'b1;
    @(posedge clk);
    exp_im = exp_s1_im; exp_hb = exp_s1_hb; exp_vb = exp_s1_vb;
    exp_s1_im = model_im(o, s, b); exp_s1_hb = hb; exp_s1_vb = vb;
    @(negedge clk);
    ce_pixel = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    CS = 1'b1; RWn = 1'b0; DSn = 1'b0; MA = a; MDin = d;
    #1;
    checks++;
    if (DTACKn !== 1'b1) begin
      errors++; $display("FAIL wr_dtack_early reg%0d: DTACKn=%b want 1", a, DTACKn);
    end
    @(posedge clk); #1;
    checks++;
    if (DTACKn !== 1'b0) begin
      errors++; $display("FAIL wr_dtack reg%0d: DTACKn=%b want 0", a, DTACKn);
    end
    mreg[a] = d;
    @(negedge clk);
    CS = 1'b0; RWn = 1'b1; DSn = 1'b1;
  endtask

  task automatic cpu_read(input logic [3:0] a, input logic [7:0] want);
    @(negedge clk);
    CS = 1'b1; RWn = 1'b1; DSn = 1'b0; MA = a;
    #1;
    checks++;
    if (DTACKn !== 1'b1) begin
      errors++; $display("FAIL rd_dtack_early reg%0d: DTACKn=%b want 1", a, DTACKn);
    end
    @(posedge clk); #1;
    checks++;
    if (DTACKn !== 1'b0 || MDout !== want) begin
      errors++;
      $display("FAIL rd reg%0d: DTACKn=%b MDout=%h want DTACKn=0 MDout=%h", a, DTACKn, MDout, want);
    end
    @(negedge clk);
    CS = 1'b0; DSn = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce_pixel = 1'b0; CS = 1'b0; RWn = 1'b1; DSn = 1'b1; MA = '0; MDin = '0;
    HBLANKn = 1'b1; VBLANKn = 1'b1; OBJ = '0; SCA = '0; SCB = '0;
    model_reset();
    #3;
    checks++;
    if (IM !== 14'h0 || OHBLANKn !== 1'b0 || OVBLANKn !== 1'b0 || MDout !== 8'h0 || DTACKn !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: IM=%h OHB=%b OVB=%b MDout=%h DTACKn=%b want 0/0/0/0/1",
               IM, OHBLANKn, OVBLANKn, MDout, DTACKn);
    end
    @(negedge clk); reset = 1'b0;
    cpu_read(4'd1, BG[7:0]);
    cpu_read(4'd2, {2'b00, BG[13:8]});
    cpu_read(4'd5, 8'h00);
  endtask

  task automatic test_priority();
    cpu_write(4'd4, 8'h21);
    cpu_write(4'd6, 8'h03);
    tick(16'h0012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0000) begin
      errors++; $display("FAIL latency_first_tick: IM=%h want 0000", IM);
    end
    tick(16'h0012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0105) begin
      errors++; $display("FAIL sca_over_obj: IM=%h want 0105", IM);
    end
    tick(16'h4012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    tick(16'h4012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0105) begin
      errors++; $display("FAIL sca_over_obj_g1: IM=%h want 0105", IM);
    end
  endtask

  task automatic test_tie();
    cpu_write(4'd6, 8'h02);
    tick(16'h4012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    tick(16'h4012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0012) begin
      errors++; $display("FAIL tie_obj_wins: IM=%h want 0012", IM);
    end
    cpu_write(4'd8, 8'h02);
    tick(16'h0010, 16'h0100, 16'h0233, 1'b1, 1'b1);
    tick(16'h0010, 16'h0100, 16'h0233, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0233) begin
      errors++; $display("FAIL scb_alone: IM=%h want 0233", IM);
    end
    // Priority change while a pixel sits in stage 2 must not affect that pixel.
    cpu_write(4'd4, 8'h21);
    tick(16'h0012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    cpu_write(4'd4, 8'h23);
    tick(16'h0012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0105) begin
      errors++; $display("FAIL latched_pri_kept: IM=%h want 0105", IM);
    end
    tick(16'h0012, 16'h0105, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0012) begin
      errors++; $display("FAIL new_pri_applied: IM=%h want 0012", IM);
    end
  endtask

  task automatic test_background();
    cpu_write(4'd1, 8'h34);
    cpu_write(4'd2, 8'h12);
    tick(16'h0010, 16'h4020, 16'hC030, 1'b1, 1'b1);
    tick(16'h0010, 16'h4020, 16'hC030, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h1234) begin
      errors++; $display("FAIL all_transparent: IM=%h want 1234", IM);
    end
    cpu_write(4'd0, 8'h01);
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h1234) begin
      errors++; $display("FAIL force_bg: IM=%h want 1234", IM);
    end
    cpu_write(4'd4, 8'h21);
    cpu_write(4'd0, 8'h00);
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    checks++;
    if (IM !== 14'h0105) begin
      errors++; $display("FAIL sca_beats_scb_tie: IM=%h want 0105", IM);
    end
  endtask

  task automatic test_blank();
    logic       hb_pat [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       vb_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       want_h [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       want_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [13:0] im_hold;
    logic        hb_hold, vb_hold;
    for (int k = 0; k < 4; k++) begin
      tick(16'h0012, 16'h0105, 16'h0000, hb_pat[k], vb_pat[k]);
      checks++;
      if (OHBLANKn !== want_h[k] || OVBLANKn !== want_v[k]) begin
        errors++;
        $display("FAIL blank_delay tick%0d: OHB=%b OVB=%b want %b %b",
                 k, OHBLANKn, OVBLANKn, want_h[k], want_v[k]);
      end
    end
    im_hold = IM; hb_hold = OHBLANKn; vb_hold = OVBLANKn;
    @(negedge clk);
    OBJ = 16'h4077; SCA = 16'h0000; SCB = 16'h8099; HBLANKn = 1'b0; VBLANKn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (IM !== im_hold || OHBLANKn !== hb_hold || OVBLANKn !== vb_hold) begin
        errors++;
        $display("FAIL ce_hold clk%0d: IM=%h OHB=%b OVB=%b want %h %b %b",
                 k, IM, OHBLANKn, OVBLANKn, im_hold, hb_hold, vb_hold);
      end
    end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    CS = 1'b1; RWn = 1'b0; DSn = 1'b0; MA = 4'd10; MDin = 8'hAA;
    @(posedge clk); #1;
    checks++;
    if (DTACKn !== 1'b0) begin
      errors++; $display("FAIL hold_ack: DTACKn=%b want 0", DTACKn);
    end
    @(negedge clk);
    MDin = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (DTACKn !== 1'b0) begin
        errors++; $display("FAIL hold_dtack clk%0d: DTACKn=%b want 0", k, DTACKn);
      end
    end
    @(negedge clk);
    CS = 1'b0; RWn = 1'b1; DSn = 1'b1;
    mreg[10] = 8'hAA;
    cpu_read(4'd10, 8'hAA);
    // Strobe with CS dropped before any clock edge: nothing is written.
    @(negedge clk);
    CS = 1'b1; RWn = 1'b0; DSn = 1'b0; MA = 4'd10; MDin = 8'h77;
    #2;
    CS = 1'b0; RWn = 1'b1; DSn = 1'b1;
    cpu_read(4'd10, 8'hAA);
  endtask

  task automatic test_random();
    logic [15:0] px [3];
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(15) == 0) cpu_write(4'd0, 8'($urandom_range(1)));
        else cpu_write(4'($urandom_range(15, 1)), 8'($urandom));
      end
      for (int l = 0; l < 3; l++) begin
        px[l] = 16'($urandom);
        if ($urandom_range(3) == 0) px[l][3:0] = 4'h0;
      end
      tick(px[0], px[1], px[2], 1'($urandom), 1'($urandom));
      checks++;
      if (IM !== exp_im || OHBLANKn !== exp_hb || OVBLANKn !== exp_vb) begin
        errors++;
        $display("FAIL random #%0d: IM=%h OHB=%b OVB=%b want %h %b %b",
                 n, IM, OHBLANKn, OVBLANKn, exp_im, exp_hb, exp_vb);
      end
    end
  endtask

  task automatic test_reset_midframe();
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (IM !== 14'h0 || OHBLANKn !== 1'b0 || OVBLANKn !== 1'b0 || DTACKn !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: IM=%h OHB=%b OVB=%b DTACKn=%b want 0/0/0/1",
               IM, OHBLANKn, OVBLANKn, DTACKn);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cpu_read(4'd4, 8'h00);
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    checks++;
    if (OHBLANKn !== 1'b0 || OVBLANKn !== 1'b0 || IM !== 14'h0) begin
      errors++;
      $display("FAIL post_reset_tick1: IM=%h OHB=%b OVB=%b want 0000 0 0", IM, OHBLANKn, OVBLANKn);
    end
    tick(16'h0012, 16'h0105, 16'h0233, 1'b1, 1'b1);
    checks++;
    if (OHBLANKn !== 1'b1 || OVBLANKn !== 1'b1 || IM !== BG) begin
      errors++;
      $display("FAIL post_reset_tick2: IM=%h OHB=%b OVB=%b want %h 1 1", IM, OHBLANKn, OVBLANKn, BG);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_tie();
    test_background();
    test_blank();
    test_handshake();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
